// File: rtl/level_scroll_ctrl_pkg.sv
// Shared game constants and the scroll controller state encoding.
package level_scroll_ctrl_pkg;

  localparam int unsigned COL_W     = 30;   // one packed column: 10 blocks x 3 bits
  localparam int unsigned BLK_W     = 3;
  localparam int unsigned COL_PX    = 40;   // pixel width of one column
  localparam int unsigned SCREEN_X0 = 120;  // X pixel of the leftmost on-screen column
  localparam int unsigned XPOS_W    = 10;
  localparam int unsigned ADDR_W    = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL_RD,
    ST_FILL_WAIT,
    ST_FILL_SHIFT,
    ST_WAIT_FRAME,
    ST_SCROLL_RD,
    ST_SCROLL_WAIT,
    ST_SCROLL_SHIFT
  } state_e;

endpackage

// File: rtl/level_scroll_ctrl_if.sv
// Control, ROM and block-array signals of the level scroll controller.
interface level_scroll_ctrl_if;
  import level_scroll_ctrl_pkg::*;

  logic              level_start;
  logic              frame_start;
  logic [XPOS_W-1:0] Mario_X_Pos;
  logic              rom_rd;
  logic [ADDR_W-1:0] rom_addr;
  logic [COL_W-1:0]  rom_data;
  logic [COL_W-1:0]  new_block_id;
  logic              Shift;
  logic              mario_shift;
  logic [ADDR_W-1:0] current_col;
  logic              busy;
  logic              level_end;

  // Environment side: game timing, Mario position and the level ROM
  modport master (
    output level_start, frame_start, Mario_X_Pos, rom_data,
    input  rom_rd, rom_addr, new_block_id, Shift, mario_shift,
           current_col, busy, level_end
  );

  // Controller side
  modport slave (
    input  level_start, frame_start, Mario_X_Pos, rom_data,
    output rom_rd, rom_addr, new_block_id, Shift, mario_shift,
           current_col, busy, level_end
  );

endinterface

// File: rtl/level_scroll_ctrl.sv
// Streams level columns from ROM into the block array: initial screen fill,
// then at most one scroll column per frame while Mario is past the scroll line.
module level_scroll_ctrl
  import level_scroll_ctrl_pkg::*;
#(
  parameter logic [XPOS_W-1:0] SCROLL_X = 10'd320,
  parameter logic [ADDR_W-1:0] NUM_COLS = 8'd200,
  parameter logic [ADDR_W-1:0] VIS_COLS = 8'd10
) (
  input  logic               Clk,
  input  logic               Reset_n,
  level_scroll_ctrl_if.slave bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] col_q, col_d, col_inc;
  logic              rom_rd_q, rom_rd_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [COL_W-1:0]  nbid_q, nbid_d;
  logic              shift_q, shift_d;
  logic              mshift_q, mshift_d;

  // State and registered outputs
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= ST_IDLE;
      col_q      <= '0;
      rom_rd_q   <= 1'b0;
      rom_addr_q <= '0;
      nbid_q     <= '0;
      shift_q    <= 1'b0;
      mshift_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      rom_rd_q   <= rom_rd_d;
      rom_addr_q <= rom_addr_d;
      nbid_q     <= nbid_d;
      shift_q    <= shift_d;
      mshift_q   <= mshift_d;
    end
  end

  // Next state and column counter; level_start overrides everything
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    col_inc = (col_q < NUM_COLS) ? col_q + ADDR_W'(1) : col_q;
    if (bus.level_start) begin
      state_d = ST_FILL_RD;
      col_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE:        state_d = ST_IDLE;
        ST_FILL_RD:     state_d = ST_FILL_WAIT;
        ST_FILL_WAIT:   state_d = ST_FILL_SHIFT;
        ST_FILL_SHIFT: begin
          col_d   = col_inc;
          // Also stop at level end in case the level is shorter than the screen
          state_d = (col_inc < VIS_COLS && col_inc < NUM_COLS) ? ST_FILL_RD : ST_WAIT_FRAME;
        end
        ST_WAIT_FRAME: begin
          if (bus.frame_start && bus.Mario_X_Pos >= SCROLL_X && col_q < NUM_COLS)
            state_d = ST_SCROLL_RD;
        end
        ST_SCROLL_RD:   state_d = ST_SCROLL_WAIT;
        ST_SCROLL_WAIT: state_d = ST_SCROLL_SHIFT;
        ST_SCROLL_SHIFT: begin
          col_d   = col_inc;
          state_d = ST_WAIT_FRAME;
        end
        default:        state_d = ST_IDLE;
      endcase
    end
  end

  // Output pulses are decoded from the next state so they line up with it
  always_comb begin
    rom_rd_d   = (state_d == ST_FILL_RD) || (state_d == ST_SCROLL_RD);
    rom_addr_d = rom_rd_d ? col_d : rom_addr_q;
    shift_d    = (state_d == ST_FILL_SHIFT) || (state_d == ST_SCROLL_SHIFT);
    mshift_d   = (state_d == ST_SCROLL_SHIFT);
    nbid_d     = shift_d ? bus.rom_data : nbid_q;
  end

  assign bus.rom_rd       = rom_rd_q;
  assign bus.rom_addr     = rom_addr_q;
  assign bus.new_block_id = nbid_q;
  assign bus.Shift        = shift_q;
  assign bus.mario_shift  = mshift_q;
  assign bus.current_col  = col_q;
  assign bus.busy         = !((state_q == ST_IDLE) || (state_q == ST_WAIT_FRAME));
  assign bus.level_end    = (col_q == NUM_COLS);

endmodule

// File: tb/tb_level_scroll_ctrl.sv
// Directed bench: dut_a uses default parameters, dut_b a 12-column level.
module tb_level_scroll_ctrl;
  import level_scroll_ctrl_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       ls, fs;
  logic [9:0] xpos;
  int         checks = 0;
  int         errors = 0;

  level_scroll_ctrl_if if_a ();
  level_scroll_ctrl_if if_b ();

  assign if_a.level_start = ls;
  assign if_a.frame_start = fs;
  assign if_a.Mario_X_Pos = xpos;
  assign if_b.level_start = ls;
  assign if_b.frame_start = fs;
  assign if_b.Mario_X_Pos = xpos;

  level_scroll_ctrl dut_a (.Clk(clk), .Reset_n(rst_n), .bus(if_a));
  level_scroll_ctrl #(.NUM_COLS(8'd12)) dut_b (.Clk(clk), .Reset_n(rst_n), .bus(if_b));

  function automatic logic [29:0] col_pat(input int k);
    logic [2:0] b;
    b = 3'(k);
    return {10{b}};
  endfunction

  // Level ROM models: one-cycle read latency
  always @(posedge clk) if (if_a.rom_rd) if_a.rom_data <= col_pat(int'(if_a.rom_addr));
  always @(posedge clk) if (if_b.rom_rd) if_b.rom_data <= col_pat(int'(if_b.rom_addr));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        fs;
    logic [9:0]  x;
    logic        rd;
    logic [7:0]  addr;
    logic        sh;
    logic        ms;
    logic [7:0]  col;
    logic        busy;
    logic [29:0] nbid;
    logic        lend_b;
  } vec_t;

  function automatic vec_t mk(input logic f, input logic [9:0] x, input logic rd,
                              input logic [7:0] addr, input logic sh, input logic ms,
                              input logic [7:0] col, input logic busy,
                              input logic [29:0] nbid, input logic lend_b);
    vec_t v;
    v.fs = f; v.x = x; v.rd = rd; v.addr = addr; v.sh = sh; v.ms = ms;
    v.col = col; v.busy = busy; v.nbid = nbid; v.lend_b = lend_b;
    return v;
  endfunction

  // Full fill from column 0 on both DUTs, optionally with a coincident frame_start
  task automatic do_fill(input string tag, input logic with_fs);
    int na, nb, nms;
    na = 0; nb = 0; nms = 0;
    ls = 1'b1; fs = with_fs; xpos = 10'd400;
    step();
    ls = 1'b0; fs = 1'b0;
    chk({tag, "_start_rd"},    32'(if_a.rom_rd), 32'd1);
    chk({tag, "_start_addr"},  32'(if_a.rom_addr), 32'd0);
    chk({tag, "_start_shift"}, 32'(if_a.Shift), 32'd0);
    chk({tag, "_start_col"},   32'(if_a.current_col), 32'd0);
    chk({tag, "_start_addr_b"}, 32'(if_b.rom_addr), 32'd0);
    for (int i = 1; i <= 30; i++) begin
      step();
      if (if_a.Shift) begin
        chk({tag, "_spacing"}, 32'(i), 32'(2 + 3 * na));
        chk({tag, "_nbid"}, 32'(if_a.new_block_id), 32'(col_pat(na)));
        na++;
      end
      if (if_b.Shift) nb++;
      if (if_a.mario_shift || if_b.mario_shift) nms++;
    end
    chk({tag, "_shifts_a"}, 32'(na), 32'd10);
    chk({tag, "_shifts_b"}, 32'(nb), 32'd10);
    chk({tag, "_mario_shift"}, 32'(nms), 32'd0);
    chk({tag, "_col_a"}, 32'(if_a.current_col), 32'd10);
    chk({tag, "_col_b"}, 32'(if_b.current_col), 32'd10);
    chk({tag, "_busy"}, 32'(if_a.busy), 32'd0);
    chk({tag, "_last_nbid"}, 32'(if_a.new_block_id), 32'(col_pat(1)));
  endtask

  initial begin
    vec_t tbl[11];
    int   sa, sb, rb;

    rst_n = 1'b0; ls = 1'b0; fs = 1'b0; xpos = '0;
    step(); step();
    chk("rst_rd",    32'(if_a.rom_rd), 32'd0);
    chk("rst_addr",  32'(if_a.rom_addr), 32'd0);
    chk("rst_nbid",  32'(if_a.new_block_id), 32'd0);
    chk("rst_shift", 32'(if_a.Shift), 32'd0);
    chk("rst_col",   32'(if_a.current_col), 32'd0);
    chk("rst_busy",  32'(if_a.busy), 32'd0);
    chk("rst_lend",  32'(if_a.level_end), 32'd0);
    rst_n = 1'b1;
    step();
    chk("idle_busy", 32'(if_a.busy), 32'd0);

    do_fill("fill", 1'b0);

    // Scroll / no-scroll vectors, starting in WAIT_FRAME with 10 columns loaded
    tbl[0]  = mk(1'b1, 10'd319, 1'b0, 8'd9,  1'b0, 1'b0, 8'd10, 1'b0, col_pat(9),  1'b0);
    tbl[1]  = mk(1'b0, 10'd319, 1'b0, 8'd9,  1'b0, 1'b0, 8'd10, 1'b0, col_pat(9),  1'b0);
    tbl[2]  = mk(1'b1, 10'd320, 1'b1, 8'd10, 1'b0, 1'b0, 8'd10, 1'b1, col_pat(9),  1'b0);
    tbl[3]  = mk(1'b0, 10'd320, 1'b0, 8'd10, 1'b0, 1'b0, 8'd10, 1'b1, col_pat(9),  1'b0);
    tbl[4]  = mk(1'b0, 10'd320, 1'b0, 8'd10, 1'b1, 1'b1, 8'd10, 1'b1, col_pat(10), 1'b0);
    tbl[5]  = mk(1'b1, 10'd400, 1'b0, 8'd10, 1'b0, 1'b0, 8'd11, 1'b0, col_pat(10), 1'b0);
    tbl[6]  = mk(1'b0, 10'd400, 1'b0, 8'd10, 1'b0, 1'b0, 8'd11, 1'b0, col_pat(10), 1'b0);
    tbl[7]  = mk(1'b1, 10'd400, 1'b1, 8'd11, 1'b0, 1'b0, 8'd11, 1'b1, col_pat(10), 1'b0);
    tbl[8]  = mk(1'b0, 10'd400, 1'b0, 8'd11, 1'b0, 1'b0, 8'd11, 1'b1, col_pat(10), 1'b0);
    tbl[9]  = mk(1'b0, 10'd400, 1'b0, 8'd11, 1'b1, 1'b1, 8'd11, 1'b1, col_pat(11), 1'b0);
    tbl[10] = mk(1'b0, 10'd400, 1'b0, 8'd11, 1'b0, 1'b0, 8'd12, 1'b0, col_pat(11), 1'b1);

    for (int i = 0; i < 11; i++) begin
      fs = tbl[i].fs; xpos = tbl[i].x;
      step();
      chk($sformatf("vec%0d_rd", i),    32'(if_a.rom_rd), 32'(tbl[i].rd));
      chk($sformatf("vec%0d_addr", i),  32'(if_a.rom_addr), 32'(tbl[i].addr));
      chk($sformatf("vec%0d_shift", i), 32'(if_a.Shift), 32'(tbl[i].sh));
      chk($sformatf("vec%0d_mshift", i), 32'(if_a.mario_shift), 32'(tbl[i].ms));
      chk($sformatf("vec%0d_col", i),   32'(if_a.current_col), 32'(tbl[i].col));
      chk($sformatf("vec%0d_busy", i),  32'(if_a.busy), 32'(tbl[i].busy));
      chk($sformatf("vec%0d_nbid", i),  32'(if_a.new_block_id), 32'(tbl[i].nbid));
      chk($sformatf("vec%0d_shift_b", i), 32'(if_b.Shift), 32'(tbl[i].sh));
      chk($sformatf("vec%0d_lend_b", i), 32'(if_b.level_end), 32'(tbl[i].lend_b));
    end
    fs = 1'b0;

    // Level end: dut_b saturated at 12 must not scroll, dut_a keeps going
    sa = 0; sb = 0; rb = 0;
    for (int f = 0; f < 4; f++) begin
      fs = 1'b1; xpos = 10'd400;
      step();
      fs = 1'b0;
      if (if_a.Shift) sa++;
      if (if_b.Shift) sb++;
      if (if_b.rom_rd) rb++;
      for (int c = 0; c < 3; c++) begin
        step();
        if (if_a.Shift) sa++;
        if (if_b.Shift) sb++;
        if (if_b.rom_rd) rb++;
      end
      chk($sformatf("lend_b_f%0d", f), 32'(if_b.level_end), 32'd1);
    end
    chk("lend_shifts_a", 32'(sa), 32'd4);
    chk("lend_shifts_b", 32'(sb), 32'd0);
    chk("lend_rd_b", 32'(rb), 32'd0);
    chk("lend_col_a", 32'(if_a.current_col), 32'd16);
    chk("lend_col_b", 32'(if_b.current_col), 32'd12);
    chk("lend_a", 32'(if_a.level_end), 32'd0);

    // Abort: level_start while dut_a is in SCROLL_WAIT
    fs = 1'b1; xpos = 10'd400;
    step();
    fs = 1'b0;
    chk("abort_pre_rd", 32'(if_a.rom_rd), 32'd1);
    chk("abort_pre_addr", 32'(if_a.rom_addr), 32'd16);
    step();
    chk("abort_in_wait", 32'(dut_a.state_q), 32'(ST_SCROLL_WAIT));
    do_fill("abort", 1'b0);

    // Coincident level_start and frame_start: fill wins
    do_fill("coinc", 1'b1);

    // Reset during FILL_WAIT of column 1
    ls = 1'b1;
    step();
    ls = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("prerst_state", 32'(dut_a.state_q), 32'(ST_FILL_WAIT));
    chk("prerst_addr", 32'(if_a.rom_addr), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_rd",    32'(if_a.rom_rd), 32'd0);
    chk("midrst_addr",  32'(if_a.rom_addr), 32'd0);
    chk("midrst_nbid",  32'(if_a.new_block_id), 32'd0);
    chk("midrst_shift", 32'(if_a.Shift), 32'd0);
    chk("midrst_mshift", 32'(if_a.mario_shift), 32'd0);
    chk("midrst_col",   32'(if_a.current_col), 32'd0);
    chk("midrst_busy",  32'(if_a.busy), 32'd0);
    chk("midrst_state", 32'(dut_a.state_q), 32'(ST_IDLE));
    step(); step();
    rst_n = 1'b1;
    sa = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (if_a.Shift || if_a.rom_rd || if_a.busy) sa++;
    end
    chk("postrst_quiet", 32'(sa), 32'd0);
    chk("postrst_col", 32'(if_a.current_col), 32'd0);
    chk("postrst_state", 32'(dut_a.state_q), 32'(ST_IDLE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
